// File: rtl/rx_pkg.sv
// Shared receive-path types and constants.
// Used by the bit sampler, frame sequencer and transmit side.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SIZE,
    DATA,
    CRC,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam int   MAX_BYTES  = 16;
  localparam int   FS_W_DEF   = 4;
  localparam int   CRC_W_DEF  = 8;
  localparam int   DATA_W_DEF = 8;
  localparam int   CNT_W      = 4;
  localparam int   BL_W       = $clog2(MAX_BYTES) + 1;

endpackage

// File: rtl/rx_byte_assembler.sv
// MSB-first byte shifter with bit counter.
// byte_done/byte_nx are combinational on the 8th shift.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  output logic [DATA_W-1:0] byte_nx,
  output logic              byte_done
);

  localparam int BC_W = $clog2(DATA_W);

  logic [DATA_W-2:0] sr;
  logic [BC_W-1:0]   bcnt;

  assign byte_nx   = {sr, bit_in};
  assign byte_done = shift && (bcnt == BC_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (clr) begin
      bcnt <= '0;
    end else if (shift) begin
      sr   <= byte_nx[DATA_W-2:0];
      bcnt <= bcnt + BC_W'(1);
    end
  end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive frame controller: start, size, data, CRC, stop.
// CRC checking enabled by defining RX_CRC_CHECK_EN.
module rx_frame_sequencer
  import rx_pkg::*;
#(
  parameter int FS_W   = FS_W_DEF,
  parameter int CRC_W  = CRC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_val,
  input  logic              bit_noise,
  output logic              crc_en,
  output logic              crc_rst,
  output logic              crc_in,
  input  logic [CRC_W-1:0]  crc_out,
  output logic [DATA_W-1:0] dataout,
  output logic              dr,
  input  logic              rd,
  output logic              nf,
  output logic              over,
  output logic              fe,
  output logic              crc_err,
  output logic              frame_done,
  output logic              busy
);

  rx_state_t state, state_nx;

  logic start, sz_sh, sz_last;
  logic dt_sh, cr_sh, cr_last, st_acc;
  logic [FS_W-1:0]   fs, fs_nx;
  logic [CNT_W-1:0]  cnt;
  logic [BL_W-1:0]   bytes_left;
  logic [DATA_W-1:0] byte_nx;
  logic              byte_done;

  assign fs_nx = {fs[FS_W-2:0], bit_val};
  assign busy  = (state != IDLE);

  rx_byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .shift    (dt_sh),
    .bit_in   (bit_val),
    .byte_nx  (byte_nx),
    .byte_done(byte_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      start:   state_nx = SIZE;
      sz_last: state_nx = DATA;
      byte_done && (bytes_left == BL_W'(1)):
               state_nx = CRC;
      cr_last: state_nx = STOP;
      st_acc:  state_nx = IDLE;
      default: ;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    sz_sh   = 1'b0;
    sz_last = 1'b0;
    dt_sh   = 1'b0;
    cr_sh   = 1'b0;
    cr_last = 1'b0;
    st_acc  = 1'b0;
    unique case (state)
      IDLE: start = bit_valid && (bit_val == START_BIT)
                    && !bit_noise;
      SIZE: begin
        sz_sh   = bit_valid;
        sz_last = bit_valid && (cnt == CNT_W'(FS_W - 1));
      end
      DATA: dt_sh = bit_valid;
      CRC: begin
        cr_sh   = bit_valid;
        cr_last = bit_valid && (cnt == CNT_W'(CRC_W - 1));
      end
      STOP:    st_acc = bit_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs         <= '0;
      cnt        <= '0;
      bytes_left <= '0;
      dataout    <= '0;
      dr         <= 1'b0;
      nf         <= 1'b0;
      over       <= 1'b0;
      fe         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= st_acc;
      if (start) begin
        cnt  <= '0;
        nf   <= 1'b0;
        over <= 1'b0;
        fe   <= 1'b0;
      end
      if (sz_sh) begin
        fs  <= fs_nx;
        cnt <= sz_last ? '0 : cnt + CNT_W'(1);
      end
      // FS=0 encodes a full 16-byte frame
      if (sz_last)
        bytes_left <= (fs_nx == '0) ? BL_W'(MAX_BYTES)
                                    : BL_W'(fs_nx);
      if (cr_sh)
        cnt <= cr_last ? '0 : cnt + CNT_W'(1);
      if (bit_valid && bit_noise && busy)
        nf <= 1'b1;
      if (st_acc)
        fe <= (bit_val != STOP_BIT);
      if (byte_done) begin
        dataout    <= byte_nx;
        dr         <= 1'b1;
        bytes_left <= bytes_left - BL_W'(1);
        if (dr && !rd) over <= 1'b1;
      end else if (rd) begin
        dr <= 1'b0;
      end
    end
  end

`ifdef RX_CRC_CHECK_EN
  logic [CRC_W-1:0] rx_crc, rx_crc_nx;

  assign rx_crc_nx = {rx_crc[CRC_W-2:0], bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_en  <= 1'b0;
      crc_rst <= 1'b0;
      crc_in  <= 1'b0;
      crc_err <= 1'b0;
      rx_crc  <= '0;
    end else begin
      crc_rst <= start;
      crc_en  <= sz_sh | dt_sh;
      crc_in  <= (sz_sh | dt_sh) & bit_val;
      if (start)   crc_err <= 1'b0;
      if (cr_sh)   rx_crc  <= rx_crc_nx;
      if (cr_last) crc_err <= (rx_crc_nx != crc_out);
    end
  end
`else
  logic unused_crc;

  assign unused_crc = ^crc_out;
  assign crc_en     = 1'b0;
  assign crc_rst    = 1'b0;
  assign crc_in     = 1'b0;
  assign crc_err    = 1'b0;
`endif

endmodule
